// File: rtl/issue_buffer_if.sv
// issue_buffer_if: decode-side enqueue and execute-side issue bundle of the issue buffer.
interface issue_buffer_if #(parameter int DEPTH = 8, parameter int PAYLOAD_W = 64);
  logic                      flush;
  logic [1:0]                in_valid;
  logic                      in_ready;
  logic [2*PAYLOAD_W-1:0]    in_payload;
  logic [1:0]                in_wr_ena, in_rs_ena, in_rt_ena;
  logic [9:0]                in_wr_addr, in_rs_addr, in_rt_addr;
  logic                      ex_ready;
  logic [1:0]                out_valid;
  logic [2*PAYLOAD_W-1:0]    out_payload;
  logic [1:0]                out_wr_ena, out_rs_ena, out_rt_ena;
  logic [9:0]                out_wr_addr, out_rs_addr, out_rt_addr;
  logic [$clog2(DEPTH):0]    occupancy;
  modport master (
    output flush, in_valid, in_payload, in_wr_ena, in_wr_addr, in_rs_ena, in_rs_addr,
           in_rt_ena, in_rt_addr, ex_ready,
    input  in_ready, out_valid, out_payload, out_wr_ena, out_wr_addr, out_rs_ena,
           out_rs_addr, out_rt_ena, out_rt_addr, occupancy
  );
  modport slave (
    input  flush, in_valid, in_payload, in_wr_ena, in_wr_addr, in_rs_ena, in_rs_addr,
           in_rt_ena, in_rt_addr, ex_ready,
    output in_ready, out_valid, out_payload, out_wr_ena, out_wr_addr, out_rs_ena,
           out_rs_addr, out_rt_ena, out_rt_addr, occupancy
  );
endinterface

// File: rtl/issue_buffer.sv
// issue_buffer: dual-slot in-order instruction buffer; splits a pair on intra-pair RAW/WAW.
module issue_buffer #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64
) (
  input logic           clk,
  input logic           rst,
  issue_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  typedef struct packed {
    logic [PAYLOAD_W-1:0] pay;
    logic                 wen;
    logic [4:0]           wa;
    logic                 rse;
    logic [4:0]           rsa;
    logic                 rte;
    logic [4:0]           rta;
  } entry_t;
  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [OW-1:0] r_occ;
  entry_t        w_in [2];
  entry_t        w_e0, w_e1;
  logic          w_in_ready, w_hazard;
  logic [1:0]    w_ov;
  logic [OW-1:0] w_n_enq, w_n_deq;
  logic [AW-1:0] w_head1, w_tail1;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_in[i] = '{pay: bus.in_payload[i*PAYLOAD_W +: PAYLOAD_W],
                  wen: bus.in_wr_ena[i], wa: bus.in_wr_addr[i*5 +: 5],
                  rse: bus.in_rs_ena[i], rsa: bus.in_rs_addr[i*5 +: 5],
                  rte: bus.in_rt_ena[i], rta: bus.in_rt_addr[i*5 +: 5]};
    end
  end
  assign w_head1    = r_head + 1'b1;
  assign w_tail1    = r_tail + 1'b1;
  assign w_e0       = r_mem[r_head];
  assign w_e1       = r_mem[w_head1];
  // Only the registered count gates enqueue, so a same-cycle dequeue earns no credit.
  assign w_in_ready = r_occ <= OW'(DEPTH - 2);
  assign w_n_enq    = (w_in_ready && bus.in_valid[0]) ? (bus.in_valid[1] ? OW'(2) : OW'(1)) : '0;
  assign w_hazard   = w_e0.wen && (w_e0.wa != 5'd0) &&
                      ((w_e1.rse && w_e1.rsa == w_e0.wa) ||
                       (w_e1.rte && w_e1.rta == w_e0.wa) ||
                       (w_e1.wen && w_e1.wa == w_e0.wa));
  assign w_ov       = {(r_occ >= OW'(2)) && !w_hazard, r_occ != '0};
  assign w_n_deq    = bus.ex_ready ? OW'(w_ov[0]) + OW'(w_ov[1]) : '0;
  always_ff @(posedge clk) begin
    if (!bus.flush && w_n_enq != '0) begin
      r_mem[r_tail] <= w_in[0];
      if (w_n_enq == OW'(2)) r_mem[w_tail1] <= w_in[1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + AW'(w_n_deq);
      r_tail <= r_tail + AW'(w_n_enq);
      r_occ  <= r_occ + w_n_enq - w_n_deq;
    end
  end
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_ov;
  assign bus.out_payload = {w_e1.pay, w_e0.pay};
  assign bus.out_wr_ena  = {w_e1.wen, w_e0.wen};
  assign bus.out_wr_addr = {w_e1.wa, w_e0.wa};
  assign bus.out_rs_ena  = {w_e1.rse, w_e0.rse};
  assign bus.out_rs_addr = {w_e1.rsa, w_e0.rsa};
  assign bus.out_rt_ena  = {w_e1.rte, w_e0.rte};
  assign bus.out_rt_addr = {w_e1.rta, w_e0.rta};
  assign bus.occupancy   = r_occ;
endmodule
